// File: rtl/pc_next_if.sv
// Bundle of the control/datapath signals between the core and the next-PC unit.
// The master side (core control) drives the select and target inputs and
// observes the program counter, trap and retire status.
interface pc_next_if;
    logic        en;
    logic [1:0]  pc_src;
    logic [31:0] pc_target;
    logic [31:0] alu_result;
    logic        halt_req;
    logic        resume;
    logic [31:0] PC;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        misalign_trap;
    logic        halted;
    logic [31:0] retire_count;

    modport master (
        output en, pc_src, pc_target, alu_result, halt_req, resume,
        input  PC, pc_plus4, epc, misalign_trap, halted, retire_count
    );

    modport slave (
        input  en, pc_src, pc_target, alu_result, halt_req, resume,
        output PC, pc_plus4, epc, misalign_trap, halted, retire_count
    );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC selection and program-counter register for the single-cycle RV32I
// core. Selects PC+4, the branch/JAL target or the JALR target, traps on a
// misaligned control-transfer target, supports debug halt/resume and counts
// retired instructions.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic     clk,
    input  logic     reset,
    pc_next_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        TRAP   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [31:0] r_retire;
    logic        r_trap;
    logic        r_halted;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_nxt;
    logic        w_misalign;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Candidate next PC; JALR clears bit 0 of its target, reserved select falls back to PC+4.
    always_comb begin
        w_nxt = w_pc_plus4;
        case (bus.pc_src)
            2'b01:   w_nxt = bus.pc_target;
            2'b10:   w_nxt = {bus.alu_result[31:1], 1'b0};
            default: w_nxt = w_pc_plus4;
        endcase
    end

    // PC+4 is always aligned, so only taken branches/jumps can raise this.
    assign w_misalign = (w_nxt[1:0] != 2'b00);

    // Run/trap/halt sequencing with registered PC, epc, trap pulse, halt flag and retire count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_epc    <= 32'h0000_0000;
            r_retire <= 32'h0000_0000;
            r_trap   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_trap <= 1'b0;
                    if (bus.en) begin
                        if (w_misalign) begin
                            // Trap takes precedence over a simultaneous halt request.
                            r_epc   <= r_pc;
                            r_pc    <= TRAP_VEC;
                            r_trap  <= 1'b1;
                            r_state <= TRAP;
                        end else begin
                            r_pc     <= w_nxt;
                            r_retire <= r_retire + 32'd1;
                            if (bus.halt_req) begin
                                r_state  <= HALTED;
                                r_halted <= 1'b1;
                            end
                        end
                    end
                end
                TRAP: begin
                    // One-cycle fetch bubble at the trap vector, independent of en.
                    r_trap  <= 1'b0;
                    r_state <= RUN;
                end
                HALTED: begin
                    if (bus.resume) begin
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_trap   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC            = r_pc;
    assign bus.pc_plus4      = w_pc_plus4;
    assign bus.epc           = r_epc;
    assign bus.misalign_trap = r_trap;
    assign bus.halted        = r_halted;
    assign bus.retire_count  = r_retire;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: each step drives inputs, queues the
// expected post-edge state, then pops and compares it after the clock edge.
module tb_pc_next_unit;

    logic clk;
    logic reset;

    pc_next_if bus ();

    pc_next_unit #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] rc;
        logic [31:0] epc;
        logic        trap;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];
    int   vectors;
    int   miscompares;

    task automatic chk32(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, req);
        end
    endtask

    task automatic chk1(input string tag, input string fld, input logic obs, input logic req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, req);
        end
    endtask

    // Drive one cycle of inputs, queue expectation, clock, then check the popped entry.
    task automatic step(input string tag, input logic rst, input logic en, input logic [1:0] src,
                        input logic [31:0] tgt, input logic [31:0] alu, input logic hreq,
                        input logic res, input logic [31:0] e_pc, input logic [31:0] e_rc,
                        input logic [31:0] e_epc, input logic e_trap, input logic e_halt);
        exp_t e;
        reset          = rst;
        bus.en         = en;
        bus.pc_src     = src;
        bus.pc_target  = tgt;
        bus.alu_result = alu;
        bus.halt_req   = hreq;
        bus.resume     = res;
        e.tag = tag; e.pc = e_pc; e.rc = e_rc; e.epc = e_epc; e.trap = e_trap; e.halted = e_halt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb_q.pop_front();
            chk32(e.tag, "PC", bus.PC, e.pc);
            chk32(e.tag, "pc_plus4", bus.pc_plus4, e.pc + 32'd4);
            chk32(e.tag, "retire_count", bus.retire_count, e.rc);
            chk32(e.tag, "epc", bus.epc, e.epc);
            chk1(e.tag, "misalign_trap", bus.misalign_trap, e.trap);
            chk1(e.tag, "halted", bus.halted, e.halted);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        @(negedge clk);

        //   tag           rst en src tgt           alu           hr rs  PC            rc  epc   trap halt
        step("reset",      1, 0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0000, 0,  32'h0,  0, 0);
        step("seq1",       0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0004, 1,  32'h0,  0, 0);
        step("seq2",       0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0008, 2,  32'h0,  0, 0);
        step("seq3",       0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_000C, 3,  32'h0,  0, 0);
        step("seq4",       0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0010, 4,  32'h0,  0, 0);
        step("branch",     0, 1, 2'b01, 32'h40,       32'h0,        0, 0, 32'h0000_0040, 5,  32'h0,  0, 0);
        step("jalr_bit0",  0, 1, 2'b10, 32'h0,        32'h85,       0, 0, 32'h0000_0084, 6,  32'h0,  0, 0);
        step("trap_entry", 0, 1, 2'b01, 32'h92,       32'h0,        0, 0, 32'h0000_0100, 6,  32'h84, 1, 0);
        step("trap_bubble",0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0100, 6,  32'h84, 0, 0);
        step("after_trap", 0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0104, 7,  32'h84, 0, 0);
        for (int i = 0; i < 3; i++)
            step("stall",  0, 0, 2'b01, 32'h92,       32'h0,        1, 0, 32'h0000_0104, 7,  32'h84, 0, 0);
        step("jump20",     0, 1, 2'b01, 32'h20,       32'h0,        0, 0, 32'h0000_0020, 8,  32'h84, 0, 0);
        step("halt_entry", 0, 1, 2'b00, 32'h0,        32'h0,        1, 0, 32'h0000_0024, 9,  32'h84, 0, 1);
        for (int i = 0; i < 5; i++)
            step("halt_hold",0, 1, 2'b00, 32'h0,      32'h0,        1, 0, 32'h0000_0024, 9,  32'h84, 0, 1);
        step("resume",     0, 1, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0024, 9,  32'h84, 0, 0);
        step("restart",    0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0028, 10, 32'h84, 0, 0);
        step("jump_top",   0, 1, 2'b01, 32'hFFFF_FFFC,32'h0,        0, 1, 32'hFFFF_FFFC, 11, 32'h84, 0, 0);
        step("wrap",       0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0000, 12, 32'h84, 0, 0);
        step("seq_a",      0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0004, 13, 32'h84, 0, 0);
        step("jalr_trap",  0, 1, 2'b10, 32'h0,        32'h7,        1, 0, 32'h0000_0100, 13, 32'h4,  1, 0);
        step("reset_trap", 1, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0000, 0,  32'h0,  0, 0);
        step("post_reset", 0, 1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0004, 1,  32'h0,  0, 0);
        step("src_rsvd",   0, 1, 2'b11, 32'h92,       32'h93,       0, 0, 32'h0000_0008, 2,  32'h0,  0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Next-PC selection and program-counter register for the single-cycle RV32I core. It sits directly downstream of the branch/jump target adder and consumes its pc_target result, the ALU result for JALR, and the control unit's pc_src select. It registers the PC that drives instruction memory. It also handles misaligned-target traps, debug halt/resume, and an instruction-retire count.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded when a misaligned control-transfer target is detected

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  advance enable; 0 = stall, all state held
pc_src  input  2  next-PC select: 00 PC+4, 01 pc_target (branch taken/JAL), 10 alu_result (JALR), 11 reserved (treated as 00)
pc_target  input  32  PC + imm_ext from the target adder
alu_result  input  32  JALR target rs1+imm
halt_req  input  1  debug halt request
resume  input  1  debug resume request
PC  output  32  current program counter
pc_plus4  output  32  PC + 4, combinational
epc  output  32  PC of the instruction whose target faulted
misalign_trap  output  1  one-cycle pulse on trap entry
halted  output  1  1 while in HALTED
retire_count  output  32  instructions retired since reset

Behaviour:
- One clock and one reset; reset is synchronous and active-high. Reset has priority over everything else.
- Reset values: PC=RESET_PC, epc=0, misalign_trap=0, retire_count=0, state=RUN, halted=0.
- pc_plus4 = PC+4, truncated to 32 bits. 0xFFFF_FFFC wraps to 0x0000_0000.
- Candidate next PC (nxt):
  - pc_src 00/11: pc_plus4
  - pc_src 01: pc_target
  - pc_src 10: {alu_result[31:1],1'b0}, i.e. JALR clears bit 0 per the ISA
- The misalign condition is nxt[1:0]!=2'b00. Only 01 and 10 can trigger it.
- FSM states: RUN, TRAP, HALTED.
- RUN, en=0:
  - PC, epc, retire_count and state all held.
  - misalign_trap=0.
  - halt_req is ignored.
- RUN, en=1, no misalign:
  - PC<=nxt; retire_count<=retire_count+1 (wraps at 2^32).
  - If halt_req=1, the current instruction still retires and the next state is HALTED. Otherwise the state stays RUN.
- RUN, en=1, misalign:
  - epc<=PC; PC<=TRAP_VEC; misalign_trap=1 for exactly the following cycle (registered).
  - retire_count is not incremented. Next state is TRAP.
  - A simultaneous halt_req is dropped; the trap wins.
- TRAP (exactly one cycle, regardless of en):
  - PC held at TRAP_VEC; retire_count held. This is a fetch bubble.
  - misalign_trap is 1 in this cycle only. Next state is RUN.
- HALTED:
  - PC and retire_count held; halted=1.
  - resume=1 moves to RUN on the next edge; execution restarts from the held PC in the cycle after.
  - halt_req in HALTED has no effect.
  - resume in RUN or TRAP is ignored.
- Reset mid-operation (any state): the next edge forces the reset values. A trap pulse or halt in progress is cancelled.
- All outputs are registered except pc_plus4.
- epc changes only on trap entry and on reset.

Test Plan:
- Reset then en=1, pc_src=00 for 4 cycles -> PC: 0x0,0x4,0x8,0xC,0x10; retire_count=4; misalign_trap stays 0.
- At PC=0x10, pc_src=01, pc_target=0x40 -> PC=0x40 next cycle. Then pc_src=10, alu_result=0x85 -> PC=0x84 (bit0 cleared, no trap).
- At PC=0x84, pc_src=01, pc_target=0x92 -> PC=0x100, epc=0x84, misalign_trap=1 for one cycle, retire_count unchanged. PC stays 0x100 one extra cycle, then advances to 0x104.
- en=0 for 3 cycles with pc_src=01 and a misaligned target present -> PC, retire_count and epc unchanged; no trap pulse.
- halt_req=1 at PC=0x20 with en=1 -> PC=0x24, halted=1 and held for 5 cycles. resume=1 -> halted=0, then PC=0x28 the cycle after.
- PC=0xFFFF_FFFC, pc_src=00 -> PC=0x0. Assert reset during TRAP -> next edge PC=RESET_PC, misalign_trap=0, retire_count=0, epc=0.
